ipnuma_rx_parser: RTL and testbench
===================================

# ipnuma_rx_parser

Consumer of the XGMII-RX FIFO. Pops 72-bit frame words, parses Ethernet/IPv4/UDP headers and the IPNUMA payload, and issues one 64-bit remote memory write request per valid frame toward the PCIe TX side. Frames failing ethertype, protocol or magic checks, or truncated frames, are discarded whole without stalling the FIFO.

## Interface
- MAGIC, `MAGIC_CODE, 32-bit IPNUMA magic compared against payload
- sys_clk  in  1  system clock
- sys_rst_n  in  1  synchronous, active-low reset
- dout  in  72  FIFO word, first-word-fall-through: [71:64] per-lane control flags (1 = control byte), [63:0] data, lane n = [8n+7:8n]
- empty  in  1  FIFO empty
- rd_en  out  1  FIFO pop; word on dout consumed when rd_en && !empty
- req_valid  out  1  write request valid
- req_ready  in  1  downstream accepts request
- req_addr  out  64  target address
- req_data  out  64  write data
- req_be  out  8  byte enables
- frames_ok  out  16  accepted frame count
- frames_drop  out  16  discarded frame count

## Operation
- Word index w counts from 0 at start word (lane0 control, byte 8'hFB); 4-bit, saturates at 15.
- Terminate: any lane with control=1 and byte 8'hFD.
- Checks: w2 lanes4,5 = 8'h08,8'h00 (ethertype 0x0800); w3 lane7 = 8'h11 (UDP); w6 lanes2..5 = MAGIC, lane2 MSB.
- Payload: w7 = req_addr, w8 = req_data, lane0 MSB (big-endian); w9 lane0 = req_be.
- States:
  - IDLE: pop every word; start word -> HDR (w=1); others ignored.
  - HDR: pop; capture/check w1..w9. Check fail -> DISCARD. Terminate in w1..w8, or in lane0 of w9 -> drop, IDLE if word held terminate. w9 lane0 valid data -> EMIT.
  - EMIT: rd_en=0; req_valid=1 until req_ready; then frames_ok++ -> TAIL (-> IDLE directly if terminate was in w9).
  - TAIL: pop until terminate word -> IDLE; no count.
  - DISCARD: frames_drop++ on entry; pop until terminate -> IDLE.
- Start word seen in HDR/TAIL/DISCARD: current frame dropped (frames_drop++ if in HDR), parse restarts at w=1 on that word.
- Counters wrap at 16'hFFFF -> 0. Simultaneous ok/drop impossible (one state).
- req_addr/req_data/req_be stable whenever req_valid=1.

## Timing
- Reset: rd_en=0, req_valid=0, req_addr/req_data=0, req_be=0, counters=0, state IDLE.
- rd_en = !empty in IDLE/HDR/TAIL/DISCARD; combinational from state and empty.
- req_valid rises the cycle after w9 is popped; request held indefinitely under backpressure; FIFO not popped in EMIT.
- Sustained throughput: one word per cycle while !empty.
- Reset mid-frame: everything to reset values; remainder of frame handled as non-start words in IDLE (silently ignored).

## Configuration
- IPNUMA_RX_STATS_EN defined: frames_ok/frames_drop counters implemented as above.
- Undefined: counters removed, both outputs tied to 16'h0; parsing unchanged.

## Structure
- Shared package/header: XGMII_START 8'hFB, XGMII_TERM 8'hFD, ETHERTYPE_IPV4, IP_PROTO_UDP, word-index constants W_TYPE=2, W_PROTO=3, W_MAGIC=6, W_ADDR=7, W_DATA=8, W_BE=9, state encoding.
- One sub-module: ipnuma_lane_detect (combinational per-lane start/terminate flags from dout).

## Test plan
- Valid frame, MAGIC=32'h5AA51234, addr 64'h0000_0001_2345_6780, data 64'hDEADBEEF_CAFEF00D, be 8'hFF, req_ready=1 -> one request with those values, frames_ok=1.
- Same frame with magic 32'h5AA51235 -> no req_valid, frames_drop=1, next valid frame accepted.
- Frame terminated at w5 -> frames_drop=1, no request; back-to-back start word next cycle parsed correctly.
- req_ready low 20 cycles during EMIT with FIFO full -> rd_en=0, req fields stable, accepted on ready, then tail drained.
- Start word arriving at w4 of previous frame -> frames_drop=1, new frame's request issued.
- sys_rst_n low during HDR at w7 -> outputs reset next cycle, leftover words ignored, counters 0; without IPNUMA_RX_STATS_EN counters read 0 throughout.

Source files
------------

// File: rtl/ipnuma_rx_parser_pkg.sv
// ipnuma_rx_parser_pkg: shared XGMII/header constants, frame word indices and parser state encoding
package ipnuma_rx_parser_pkg;
   localparam logic [7:0]  XGMII_START    = 8'hFB;
   localparam logic [7:0]  XGMII_TERM     = 8'hFD;
   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [3:0]  W_TYPE         = 4'd2;
   localparam logic [3:0]  W_PROTO        = 4'd3;
   localparam logic [3:0]  W_MAGIC        = 4'd6;
   localparam logic [3:0]  W_ADDR         = 4'd7;
   localparam logic [3:0]  W_DATA         = 4'd8;
   localparam logic [3:0]  W_BE           = 4'd9;
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_EMIT, S_TAIL, S_DISCARD} state_t;
   function automatic logic [63:0] bswap64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = x[56 - 8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/ipnuma_lane_detect.sv
// ipnuma_lane_detect: combinational XGMII start (lane0) and terminate (any lane) detection on a FIFO word
module ipnuma_lane_detect
   import ipnuma_rx_parser_pkg::*;
(
   input  logic [71:0] dout,
   output logic        start,
   output logic        term
);
   logic [7:0] t;
   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign t[i] = dout[64 + i] && dout[8*i +: 8] == XGMII_TERM;
   end
   assign start = dout[64] && dout[7:0] == XGMII_START;
   assign term = |t;
endmodule

// File: rtl/ipnuma_rx_parser.sv
// ipnuma_rx_parser: parses XGMII-RX FIFO frames and issues one remote write per valid IPNUMA frame; IPNUMA_RX_STATS_EN enables frame counters
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'h5AA51234
`endif
module ipnuma_rx_parser
   import ipnuma_rx_parser_pkg::*;
#(
   parameter logic [31:0] MAGIC = `MAGIC_CODE
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [71:0] dout,
   input  logic        empty,
   output logic        rd_en,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [63:0] req_addr,
   output logic [63:0] req_data,
   output logic [7:0]  req_be,
   output logic [15:0] frames_ok,
   output logic [15:0] frames_drop
);
   state_t     state, state_n;
   logic [3:0] w, w_n;
   logic       start, term, term9, hdr_pop, chk_fail;
   ipnuma_lane_detect u_lane (.dout(dout), .start(start), .term(term));
   assign rd_en = sys_rst_n && state != S_EMIT && !empty;
   assign req_valid = state == S_EMIT;
   assign hdr_pop = state == S_HDR && rd_en && !start;
   assign chk_fail = (w == W_TYPE && {dout[39:32], dout[47:40]} != ETHERTYPE_IPV4) ||
                     (w == W_PROTO && dout[63:56] != IP_PROTO_UDP) ||
                     (w == W_MAGIC && {dout[23:16], dout[31:24], dout[39:32], dout[47:40]} != MAGIC);
   // next state and word index; a start word always restarts parsing at w=1
   always_comb begin
      state_n = state;
      w_n = w;
      if (state == S_EMIT) begin
         if (req_ready) state_n = term9 ? S_IDLE : S_TAIL;
      end else if (rd_en) begin
         if (start) begin
            state_n = S_HDR;
            w_n = 4'd1;
         end else if (state == S_HDR) begin
            w_n = (w == 4'hF) ? w : w + 4'd1;
            if (term && (w != W_BE || dout[64])) state_n = S_IDLE;
            else if (chk_fail || (w == W_BE && dout[64])) state_n = S_DISCARD;
            else if (w == W_BE) state_n = S_EMIT;
         end else if (term && state != S_IDLE) state_n = S_IDLE;
      end
   end
   // state register and payload capture; request fields only change while parsing headers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
         w <= '0;
         term9 <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
         req_be <= '0;
      end else begin
         state <= state_n;
         w <= w_n;
         if (hdr_pop && w == W_ADDR) req_addr <= bswap64(dout[63:0]);
         if (hdr_pop && w == W_DATA) req_data <= bswap64(dout[63:0]);
         if (hdr_pop && w == W_BE) begin
            req_be <= dout[7:0];
            term9 <= term;
         end
      end
   end
`ifdef IPNUMA_RX_STATS_EN
   logic ok_inc, drop_inc;
   assign ok_inc = state == S_EMIT && req_ready;
   assign drop_inc = state == S_HDR && rd_en && (start || state_n == S_IDLE || state_n == S_DISCARD);
   // wrapping accepted/discarded frame counters
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         frames_ok <= '0;
         frames_drop <= '0;
      end else begin
         frames_ok <= frames_ok + {15'd0, ok_inc};
         frames_drop <= frames_drop + {15'd0, drop_inc};
      end
   end
`else
   assign frames_ok = 16'h0;
   assign frames_drop = 16'h0;
`endif
endmodule

// File: tb/tb_ipnuma_rx_parser.sv
// tb_ipnuma_rx_parser: table-driven frame vectors plus hand-written backpressure, restart and reset sequences
module tb_ipnuma_rx_parser;
   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [71:0] dout = '0;
   logic        empty = 1'b1;
   logic        rd_en, req_valid;
   logic        req_ready = 1'b1;
   logic [63:0] req_addr, req_data;
   logic [7:0]  req_be;
   logic [15:0] frames_ok, frames_drop;
   logic [71:0] q[$];
   int          ntests = 0, nfail = 0, nreq = 0, npop = 0;
   logic [63:0] got_addr = '0, got_data = '0;
   logic [7:0]  got_be = '0;
   logic [15:0] eok = '0, edrop = '0;
   localparam logic [71:0] TERMW = {8'hFF, 64'h0707_0707_0707_07FD};

   typedef struct {
      logic [31:0] magic;
      logic [15:0] etype;
      logic [7:0]  proto;
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
      int          term_at;
      bit          t9;
      int          tail;
      bit          exp_req;
   } vec_t;
   vec_t v[9];

   ipnuma_rx_parser #(.MAGIC(32'h5AA51234)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dout(dout), .empty(empty), .rd_en(rd_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
      .req_be(req_be), .frames_ok(frames_ok), .frames_drop(frames_drop)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [63:0] bsw(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = x[56 - 8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_counts(input string tag);
`ifdef IPNUMA_RX_STATS_EN
      chk({tag, " frames_ok"}, 64'(frames_ok), 64'(eok));
      chk({tag, " frames_drop"}, 64'(frames_drop), 64'(edrop));
`else
      chk({tag, " frames_ok"}, 64'(frames_ok), 64'h0);
      chk({tag, " frames_drop"}, 64'(frames_drop), 64'h0);
`endif
   endtask

   // one clock: FIFO model pops on rd_en && !empty, handshakes are recorded
   task automatic tick();
      logic fire;
      fire = rd_en && !empty;
      if (req_valid && req_ready) begin
         nreq++;
         got_addr = req_addr;
         got_data = req_data;
         got_be = req_be;
      end
      @(posedge sys_clk);
      if (fire) begin
         q.delete(0);
         npop++;
      end
      @(negedge sys_clk);
      dout = q.size() != 0 ? q[0] : 72'h0;
      empty = q.size() == 0;
      #1;
   endtask

   // cut != 0 stops the frame before word 'cut' with no terminate
   task automatic push_frame(input vec_t f, input int cut);
      logic [71:0] fw[10];
      fw[0] = {8'h01, 64'hD555_5555_5555_55FB};
      fw[1] = {8'h00, 64'h0011_2233_4455_6677};
      fw[2] = {8'h00, 16'hAABB, f.etype[7:0], f.etype[15:8], 32'h4455_6677};
      fw[3] = {8'h00, f.proto, 56'h40_0000_1C00_4500};
      fw[4] = {8'h00, 64'h0A00_0001_0A00_0002};
      fw[5] = {8'h00, 64'h1234_5678_0040_0000};
      fw[6] = {8'h00, 16'h1357, f.magic[7:0], f.magic[15:8], f.magic[23:16], f.magic[31:24], 16'h2468};
      fw[7] = {8'h00, bsw(f.addr)};
      fw[8] = {8'h00, bsw(f.data)};
      fw[9] = f.t9 ? {8'hF0, 32'h0707_07FD, 24'h00_0000, f.be} : {8'h00, 56'h9988_7766_5544_33, f.be};
      for (int i = 0; i < 10; i++) begin
         if (cut != 0 && i == cut) return;
         if (f.term_at != 0 && i == f.term_at) begin
            q.push_back(TERMW);
            return;
         end
         q.push_back(fw[i]);
      end
      if (!f.t9) begin
         for (int i = 0; i < f.tail; i++) q.push_back({8'h00, 56'hEE_EEEE_EEEE_EEEE, 8'(i)});
         q.push_back(TERMW);
      end
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((q.size() != 0 || req_valid) && k < 300) begin
         tick();
         k++;
      end
      tick();
      tick();
      chk({tag, " drained"}, 64'(q.size() != 0 || req_valid), 64'h0);
   endtask

   task automatic chk_req(input string tag, input vec_t f);
      chk({tag, " addr"}, got_addr, f.addr);
      chk({tag, " data"}, got_data, f.data);
      chk({tag, " be"}, 64'(got_be), 64'(f.be));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      vec_t f;
      v[0] = '{32'h5AA51234, 16'h0800, 8'h11, 64'h0000_0001_2345_6780, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0, 2, 1'b1};
      v[1] = '{32'h5AA51235, 16'h0800, 8'h11, 64'h0000_0001_2345_6780, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0, 2, 1'b0};
      v[2] = '{32'h5AA51234, 16'h0800, 8'h11, 64'hFFFF_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 8'h0F, 0, 1'b0, 0, 1'b1};
      v[3] = '{32'h5AA51234, 16'h0800, 8'h11, 64'h0000_0001_2345_6780, 64'hDEADBEEF_CAFEF00D, 8'hFF, 5, 1'b0, 2, 1'b0};
      v[4] = '{32'h5AA51234, 16'h86DD, 8'h11, 64'h0000_0001_2345_6780, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0, 1, 1'b0};
      v[5] = '{32'h5AA51234, 16'h0800, 8'h06, 64'h0000_0001_2345_6780, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0, 1, 1'b0};
      v[6] = '{32'h5AA51234, 16'h0800, 8'h11, 64'h0000_0000_0000_1000, 64'h1111_2222_3333_4444, 8'h3C, 0, 1'b1, 0, 1'b1};
      v[7] = '{32'h5AA51234, 16'h0800, 8'h11, 64'h0000_0001_2345_6780, 64'hDEADBEEF_CAFEF00D, 8'hFF, 9, 1'b0, 0, 1'b0};
      v[8] = '{32'h5AA51234, 16'h0800, 8'h11, 64'h0000_0001_2345_6780, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1, 1'b0, 0, 1'b0};

      q.push_back({8'h00, 64'h1});
      repeat (3) tick();
      chk("reset rd_en", 64'(rd_en), 64'h0);
      chk("reset req_valid", 64'(req_valid), 64'h0);
      chk("reset req_addr", req_addr, 64'h0);
      chk("reset req_data", req_data, 64'h0);
      chk("reset req_be", 64'(req_be), 64'h0);
      chk_counts("reset");
      sys_rst_n = 1'b1;
      drain("post-reset junk");

      for (int i = 0; i < 9; i++) begin
         r0 = nreq;
         push_frame(v[i], 0);
         drain($sformatf("v%0d", i));
         chk($sformatf("v%0d req count", i), 64'(nreq - r0), 64'(v[i].exp_req));
         if (v[i].exp_req) begin
            chk_req($sformatf("v%0d", i), v[i]);
            eok++;
         end else edrop++;
         chk_counts($sformatf("v%0d", i));
      end

      r0 = nreq;
      push_frame(v[3], 0);
      push_frame(v[0], 0);
      drain("b2b");
      chk("b2b req count", 64'(nreq - r0), 64'h1);
      chk_req("b2b", v[0]);
      edrop++;
      eok++;
      chk_counts("b2b");

      r0 = nreq;
      push_frame(v[0], 4);
      push_frame(v[2], 0);
      drain("restart");
      chk("restart req count", 64'(nreq - r0), 64'h1);
      chk_req("restart", v[2]);
      edrop++;
      eok++;
      chk_counts("restart");

      r0 = nreq;
      req_ready = 1'b0;
      f = v[0];
      f.tail = 30;
      push_frame(f, 0);
      for (int k = 0; k < 100 && !req_valid; k++) tick();
      chk("bp reached emit", 64'(req_valid), 64'h1);
      begin
         int qs;
         qs = q.size();
         for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp rd_en", 64'(rd_en), 64'h0);
            chk("bp req_valid", 64'(req_valid), 64'h1);
            chk("bp req_addr", req_addr, f.addr);
            chk("bp req_data", req_data, f.data);
            chk("bp req_be", 64'(req_be), 64'(f.be));
         end
         chk("bp fifo untouched", 64'(q.size()), 64'(qs));
      end
      req_ready = 1'b1;
      drain("bp");
      chk("bp req count", 64'(nreq - r0), 64'h1);
      chk_req("bp", f);
      eok++;
      chk_counts("bp");

      r0 = nreq;
      begin
         int p0;
         p0 = npop;
         push_frame(v[0], 0);
         for (int k = 0; k < 50 && npop - p0 < 7; k++) tick();
         chk("rst popped to w7", 64'(npop - p0), 64'd7);
      end
      sys_rst_n = 1'b0;
      #1;
      chk("rst rd_en", 64'(rd_en), 64'h0);
      tick();
      chk("rst req_valid", 64'(req_valid), 64'h0);
      chk("rst req_addr", req_addr, 64'h0);
      chk("rst req_data", req_data, 64'h0);
      chk("rst req_be", 64'(req_be), 64'h0);
      eok = '0;
      edrop = '0;
      chk_counts("rst");
      sys_rst_n = 1'b1;
      drain("rst leftover");
      chk("rst leftover req count", 64'(nreq - r0), 64'h0);
      chk("rst leftover req_addr", req_addr, 64'h0);
      chk_counts("rst leftover");

      r0 = nreq;
      push_frame(v[2], 0);
      drain("recover");
      chk("recover req count", 64'(nreq - r0), 64'h1);
      chk_req("recover", v[2]);
      eok++;
      chk_counts("recover");

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
